alu_seq: RTL and testbench

Parametrised, multi-cycle ALU for the accumulator datapath. Accepts an operation plus accumulator and bus operands through a start/busy/done handshake, and runs single-cycle logic and arithmetic. Shifts run one bit per cycle; unsigned multiply uses shift-add over WIDTH cycles. Result and Z/N/C/V flags are registered and hold until the next operation completes.

---
 rtl/alu_seq_if.sv | 33 +++
 rtl/alu_seq.sv | 202 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Start/busy/done handshake and operand/result bundle for alu_seq.
// The master issues operations; the slave is the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, op, a, b,
        input  result, result_hi,
        input  flag_z, flag_n, flag_c, flag_v,
        input  busy, done, err
    );

    modport slave (
        input  start, op, a, b,
        output result, result_hi,
        output flag_z, flag_n, flag_c, flag_v,
        output busy, done, err
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle accumulator ALU: single-cycle logic/arith,
// bit-serial shifts and shift-add unsigned multiply.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_INC  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_PASS = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_ASR  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    localparam logic [SW:0] CNT_MUL = (SW+1)'(WIDTH);

    logic [1:0]       state;
    logic             armed;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [SW:0]      cnt;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] hi;
    logic             sc;

    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] hi_q;
    logic             z_q;
    logic             n_q;
    logic             c_q;
    logic             v_q;

    logic             rsv;
    logic [WIDTH-1:0] add_b;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [WIDTH:0]   mac;
    logic [WIDTH-1:0] nres;
    logic [WIDTH-1:0] nhi;
    logic             nc;
    logic             nv;
    logic             nz;

    assign rsv = (op_q[3:2] == 2'b11);

    // One adder serves ADD, SUB (a + ~b + 1) and INC (a + 0 + 1).
    always_comb begin
        add_b = '0;
        cin   = 1'b0;
        unique case (op_q)
            OP_ADD:  add_b = b_q;
            OP_SUB:  begin add_b = ~b_q; cin = 1'b1; end
            OP_INC:  cin = 1'b1;
            default: ;
        endcase
        sum = {1'b0, a_q} + {1'b0, add_b} + {{WIDTH{1'b0}}, cin};
        ovf = (a_q[WIDTH-1] == add_b[WIDTH-1]) &&
              (sum[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_comb begin
        mac = {1'b0, hi};
        if (work[0])
            mac = {1'b0, hi} + {1'b0, a_q};
    end

    always_comb begin
        nres = '0;
        nhi  = '0;
        nc   = 1'b0;
        nv   = 1'b0;
        unique case (op_q)
            OP_ADD, OP_SUB, OP_INC: begin
                nres = sum[WIDTH-1:0];
                nc   = sum[WIDTH];
                nv   = ovf;
            end
            OP_AND:  nres = a_q & b_q;
            OP_OR:   nres = a_q | b_q;
            OP_XOR:  nres = a_q ^ b_q;
            OP_NOT:  nres = ~a_q;
            OP_PASS: nres = b_q;
            OP_SHL, OP_SHR, OP_ASR: begin
                nres = work;
                nc   = sc;
            end
            OP_MUL: begin
                nres = work;
                nhi  = hi;
                nc   = |hi;
            end
            default: ;
        endcase
        nz = (nres == '0) && (nhi == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            armed <= 1'b0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt   <= '0;
            work  <= '0;
            hi    <= '0;
            sc    <= 1'b0;
            res_q <= '0;
            hi_q  <= '0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    // Accepted start takes one edge before RUN begins.
                    if (armed) begin
                        armed <= 1'b0;
                        state <= S_RUN;
                    end else if (bus.start) begin
                        armed <= 1'b1;
                        op_q  <= bus.op;
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        hi    <= '0;
                        sc    <= 1'b0;
                        work  <= (bus.op == OP_MUL) ? bus.b : bus.a;
                        unique case (bus.op)
                            OP_SHL, OP_SHR, OP_ASR:
                                cnt <= {1'b0, bus.b[SW-1:0]};
                            OP_MUL:  cnt <= CNT_MUL;
                            default: cnt <= '0;
                        endcase
                    end
                end
                S_RUN: begin
                    if (cnt == '0) begin
                        res_q <= nres;
                        hi_q  <= nhi;
                        if (!rsv) begin
                            z_q <= nz;
                            n_q <= nres[WIDTH-1];
                            c_q <= nc;
                            v_q <= nv;
                        end
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                        unique case (op_q)
                            OP_SHL: begin
                                sc   <= work[WIDTH-1];
                                work <= {work[WIDTH-2:0], 1'b0};
                            end
                            OP_SHR: begin
                                sc   <= work[0];
                                work <= {1'b0, work[WIDTH-1:1]};
                            end
                            OP_ASR: begin
                                sc   <= work[0];
                                work <= {work[WIDTH-1], work[WIDTH-1:1]};
                            end
                            OP_MUL: begin
                                hi   <= mac[WIDTH:1];
                                work <= {mac[0], work[WIDTH-1:1]};
                            end
                            default: ;
                        endcase
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.result    = res_q;
    assign bus.result_hi = hi_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;
    assign bus.busy      = (state == S_RUN) || (state == S_DONE);
    assign bus.done      = (state == S_DONE);
    assign bus.err       = (state == S_DONE) && rsv;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed ops push expectations,
// a monitor pops and checks on every done pulse.
module tb_alu_seq;
    logic clk;
    logic rst;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic [7:0] res;
        logic [7:0] hi;
        logic [3:0] fl;
        logic       err;
        int         at;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: edge counter plus checking 1ns after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (!rst && bus.done) begin
            if (q.size() == 0) begin
                check("unexpected_done", int'(bus.done), 0);
            end else begin
                e = q.pop_front();
                check({e.name, "_result"}, int'(bus.result), int'(e.res));
                check({e.name, "_result_hi"}, int'(bus.result_hi), int'(e.hi));
                check({e.name, "_flags_zncv"},
                      int'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}),
                      int'(e.fl));
                check({e.name, "_err"}, int'(bus.err), int'(e.err));
                check({e.name, "_done_edge"}, cyc, e.at);
            end
        end
    end

    // Called at a falling edge; returns at a falling edge with the DUT idle.
    task automatic run_op(string nm, logic [3:0] op, logic [7:0] a,
                          logic [7:0] b, logic [7:0] res, logic [7:0] hi,
                          logic [3:0] fl, logic err, int lat, bit poke);
        exp_t e;
        int   bcnt;
        e.name = nm;
        e.res  = res;
        e.hi   = hi;
        e.fl   = fl;
        e.err  = err;
        e.at   = cyc + 1 + lat;
        q.push_back(e);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bcnt = bus.busy ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (poke && i == 2) begin
                bus.start = 1'b1;
                bus.op    = 4'd0;
                bus.a     = 8'h01;
                bus.b     = 8'h01;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy) bcnt++;
            if (q.size() == 0) break;
        end
        if (q.size() != 0) begin
            check({nm, "_timeout"}, q.size(), 0);
            q.delete();
        end
        @(negedge clk);
        if (bus.busy) bcnt++;
        check({nm, "_busy_cycles"}, bcnt, lat);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 4'd0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_outputs",
              int'({bus.result, bus.result_hi, bus.flag_z, bus.flag_n,
                    bus.flag_c, bus.flag_v, bus.busy, bus.done, bus.err}),
              0);

        //     name       op     a      b      res    hi     zncv     err lat poke
        run_op("add_ovf", 4'd0,  8'h7F, 8'h01, 8'h80, 8'h00, 4'b0101, 0, 2,  0);
        run_op("sub_eq",  4'd1,  8'h05, 8'h05, 8'h00, 8'h00, 4'b1010, 0, 2,  0);
        run_op("sub_brw", 4'd1,  8'h03, 8'h05, 8'hFE, 8'h00, 4'b0100, 0, 2,  0);
        run_op("inc_ovf", 4'd2,  8'h7F, 8'h00, 8'h80, 8'h00, 4'b0101, 0, 2,  0);
        run_op("and",     4'd3,  8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 0, 2,  0);
        run_op("xor_z",   4'd5,  8'hAA, 8'hAA, 8'h00, 8'h00, 4'b1000, 0, 2,  0);
        run_op("not",     4'd6,  8'h0F, 8'h00, 8'hF0, 8'h00, 4'b0100, 0, 2,  0);
        run_op("shl3",    4'd8,  8'h81, 8'h03, 8'h08, 8'h00, 4'b0000, 0, 5,  0);
        run_op("shr1",    4'd9,  8'h81, 8'h01, 8'h40, 8'h00, 4'b0010, 0, 3,  0);
        run_op("asr7",    4'd10, 8'h80, 8'h07, 8'hFF, 8'h00, 4'b0100, 0, 9,  0);
        run_op("shr0",    4'd9,  8'hB6, 8'h00, 8'hB6, 8'h00, 4'b0100, 0, 2,  0);
        run_op("mul_ff",  4'd11, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0010, 0, 10, 0);
        run_op("mul_z",   4'd11, 8'h00, 8'h37, 8'h00, 8'h00, 4'b1000, 0, 10, 0);
        run_op("mul_pok", 4'd11, 8'h0D, 8'h0B, 8'h8F, 8'h00, 4'b0100, 0, 10, 1);
        run_op("rsv13",   4'd13, 8'h05, 8'h05, 8'h00, 8'h00, 4'b0100, 1, 2,  0);

        // Abort a multiply part-way through with reset.
        bus.start = 1'b1;
        bus.op    = 4'd11;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_outputs",
              int'({bus.result, bus.result_hi, bus.flag_z, bus.flag_n,
                    bus.flag_c, bus.flag_v, bus.busy, bus.done, bus.err}),
              0);
        @(negedge clk);
        rst = 1'b0;
        run_op("add_post", 4'd0, 8'h01, 8'h01, 8'h02, 8'h00, 4'b0000, 0, 2, 0);
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
